// File: rtl/score_flash_pkg.sv
// -----------------------------------------------------------------------------
// score_flash_pkg
// Shared definitions for the score flash sequencer and its register file:
//   - sequencer state encoding (state_t)
//   - bridge direction constants (DIR_READ / DIR_WRITE)
//   - default geometry (DEF_NUM_BYTES, DEF_BASE_ADDR)
//   - byte counter width (CNT_W), wide enough for 16 bytes plus a checksum slot
// Optional feature macro used by the other files: SCORE_FLASH_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package score_flash_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_NEXT    = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    localparam logic DIR_READ  = 1'b1;
    localparam logic DIR_WRITE = 1'b0;

    localparam int         DEF_NUM_BYTES = 8;
    localparam logic [7:0] DEF_BASE_ADDR = 8'h00;

    // Indexes 0..16 must fit: up to 16 data bytes plus one checksum transfer.
    localparam int CNT_W = 5;

endpackage

// File: rtl/score_regfile.sv
// -----------------------------------------------------------------------------
// score_regfile
// NUM_BYTES x 8 score register file: synchronous write, asynchronous read,
// synchronous clear on rst.
// Ports:
//   clk, rst            clock, synchronous active-high clear
//   we/waddr/wdata      local write port (out-of-range addresses are dropped)
//   cap_we/cap_addr/cap_data  capture write port from the sequencer; wins
//                       over the local port (the two never overlap in use)
//   rsel/rdata          local read port, returns 0 for rsel >= NUM_BYTES
//   ssel/sdata          sequencer read port, returns 0 for ssel >= NUM_BYTES
//   xsum                XOR of all bytes (only with SCORE_FLASH_CHECKSUM_EN)
// -----------------------------------------------------------------------------
module score_regfile
    import score_flash_pkg::*;
#(
    parameter int NUM_BYTES = DEF_NUM_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       waddr,
    input  logic [7:0]       wdata,
    input  logic             cap_we,
    input  logic [CNT_W-1:0] cap_addr,
    input  logic [7:0]       cap_data,
    input  logic [3:0]       rsel,
    output logic [7:0]       rdata,
    input  logic [CNT_W-1:0] ssel,
`ifdef SCORE_FLASH_CHECKSUM_EN
    output logic [7:0]       xsum,
`endif
    output logic [7:0]       sdata
);

    logic [7:0] mem [NUM_BYTES];

    // Address decode by comparison keeps out-of-range indexes harmless
    // without relying on array bounds behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BYTES; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (cap_we && int'(cap_addr) == i)
                    mem[i] <= cap_data;
                else if (we && int'(waddr) == i)
                    mem[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        sdata = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (int'(rsel) == i) rdata = mem[i];
            if (int'(ssel) == i) sdata = mem[i];
        end
    end

`ifdef SCORE_FLASH_CHECKSUM_EN
    always_comb begin
        xsum = '0;
        for (int i = 0; i < NUM_BYTES; i++) xsum = xsum ^ mem[i];
    end
`endif

endmodule

// File: rtl/score_flash_seq.sv
// -----------------------------------------------------------------------------
// score_flash_seq
// Saves the score register file to consecutive flash addresses, or loads it
// back, issuing one flash bridge handshake (fb_start / fb_done) per byte.
// Byte i lives at BASE_ADDR+i (8-bit wrap).
//
// Handshake: fb_start is a single-cycle trigger; addr/data_in/direction are
// valid with it and held until the bridge answers with a one-cycle fb_done.
// For reads, fb_data_out is taken the cycle after fb_done (CAPTURE).
//
// Ports:
//   CLK_50MHZ, RST       clock, synchronous active-high reset
//   save_req, load_req   start save / load (save wins; ignored while busy)
//   busy, done           operation in progress / one-cycle completion pulse
//   reg_sel/reg_we/reg_wdata/reg_rdata   local register file access
//   fb_addr, fb_data_in, fb_direction_rw, fb_start   to flash bridge
//   fb_data_out, fb_done                             from flash bridge
//   load_err             checksum mismatch on last load (optional feature)
//
// Optional feature macro SCORE_FLASH_CHECKSUM_EN: adds one transfer at
// BASE_ADDR+NUM_BYTES carrying the XOR of all bytes, plus load_err.
// -----------------------------------------------------------------------------
module score_flash_seq
    import score_flash_pkg::*;
#(
    parameter int         NUM_BYTES = DEF_NUM_BYTES,
    parameter logic [7:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       save_req,
    input  logic       load_req,
    output logic       busy,
    output logic       done,
    input  logic [3:0] reg_sel,
    input  logic       reg_we,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic [7:0] fb_addr,
    output logic [7:0] fb_data_in,
    input  logic [7:0] fb_data_out,
    output logic       fb_direction_rw,
    output logic       fb_start,
`ifdef SCORE_FLASH_CHECKSUM_EN
    output logic       load_err,
`endif
    input  logic       fb_done
);

`ifdef SCORE_FLASH_CHECKSUM_EN
    localparam int LAST = NUM_BYTES;
`else
    localparam int LAST = NUM_BYTES - 1;
`endif

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] next_idx;
    logic [7:0]       sdata;
    logic [7:0]       issue_data;

    // Index of the byte the next ISSUE will carry: 0 when starting from IDLE,
    // counter+1 when advancing from NEXT. Outputs are registered on entry to
    // ISSUE, so the data must be looked up one cycle ahead.
    assign next_idx = (state == S_NEXT) ? counter + 1'b1 : '0;

`ifdef SCORE_FLASH_CHECKSUM_EN
    logic [7:0] xsum;
    logic [7:0] chk_q;

    always_comb begin
        issue_data = sdata;
        if (int'(next_idx) == NUM_BYTES) issue_data = xsum;
    end
`else
    assign issue_data = sdata;
`endif

    score_regfile #(
        .NUM_BYTES (NUM_BYTES)
    ) u_regfile (
        .clk      (CLK_50MHZ),
        .rst      (RST),
        .we       (reg_we && !busy),
        .waddr    (reg_sel),
        .wdata    (reg_wdata),
        .cap_we   (state == S_CAPTURE),
        .cap_addr (counter),
        .cap_data (fb_data_out),
        .rsel     (reg_sel),
        .rdata    (reg_rdata),
        .ssel     (next_idx),
`ifdef SCORE_FLASH_CHECKSUM_EN
        .xsum     (xsum),
`endif
        .sdata    (sdata)
    );

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state           <= S_IDLE;
            counter         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            fb_start        <= 1'b0;
            fb_addr         <= '0;
            fb_data_in      <= '0;
            fb_direction_rw <= DIR_READ;
`ifdef SCORE_FLASH_CHECKSUM_EN
            chk_q           <= '0;
            load_err        <= 1'b0;
`endif
        end else begin
            // Single-cycle strobes; only the transitions into ISSUE / FIN raise them.
            fb_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (save_req || load_req) begin
                        state           <= S_ISSUE;
                        counter         <= '0;
                        busy            <= 1'b1;
                        fb_start        <= 1'b1;
                        fb_direction_rw <= save_req ? DIR_WRITE : DIR_READ;
                        fb_addr         <= BASE_ADDR;
                        fb_data_in      <= issue_data;
`ifdef SCORE_FLASH_CHECKSUM_EN
                        load_err        <= 1'b0;
`endif
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fb_done)
                        state <= (fb_direction_rw == DIR_READ) ? S_CAPTURE : S_NEXT;
                end
                S_CAPTURE: begin
                    // Data bytes are written by the register file capture port.
`ifdef SCORE_FLASH_CHECKSUM_EN
                    if (int'(counter) == NUM_BYTES) chk_q <= fb_data_out;
`endif
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (int'(counter) == LAST) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`ifdef SCORE_FLASH_CHECKSUM_EN
                        load_err <= (fb_direction_rw == DIR_READ) && (chk_q != xsum);
`endif
                    end else begin
                        state      <= S_ISSUE;
                        counter    <= next_idx;
                        fb_start   <= 1'b1;
                        fb_addr    <= BASE_ADDR + 8'(next_idx);
                        fb_data_in <= issue_data;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
